// File: rtl/multdiv_tracker.sv
// Issue-and-track controller for the multi-cycle multiply/divide unit: starts an op from D/X,
// exposes the in-flight instruction to the stall logic and presents a one-cycle writeback.
module multdiv_tracker #(
    parameter int TIMEOUT = 40,
    parameter int CNT_W   = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] dx_insn,
    input  logic        flush,
    input  logic        data_resultRDY,
    input  logic        data_exception,
    input  logic [31:0] data_result,
    output logic        ctrl_MULT,
    output logic        ctrl_DIV,
    output logic        mult_ongoing,
    output logic [31:0] pending_insn,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        wb_exception
);

    typedef enum logic [1:0] {IDLE, START, BUSY, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_opIsDiv;

    logic w_rType;
    logic w_isMult;
    logic w_isDiv;

    assign w_rType  = (dx_insn[31:27] == 5'b00000);
    assign w_isMult = w_rType && (dx_insn[6:2] == 5'b00110);
    assign w_isDiv  = w_rType && (dx_insn[6:2] == 5'b00111);

    // Outputs are set on the edge that enters the state they belong to, so they are all registered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_opIsDiv    <= 1'b0;
            ctrl_MULT    <= 1'b0;
            ctrl_DIV     <= 1'b0;
            mult_ongoing <= 1'b0;
            pending_insn <= 32'h0;
            wb_valid     <= 1'b0;
            wb_rd        <= 5'd0;
            wb_data      <= 32'h0;
            wb_exception <= 1'b0;
        end else begin
            ctrl_MULT    <= 1'b0;
            ctrl_DIV     <= 1'b0;
            wb_valid     <= 1'b0;
            wb_rd        <= 5'd0;
            wb_data      <= 32'h0;
            wb_exception <= 1'b0;
            case (r_state)
                IDLE: begin
                    if ((w_isMult || w_isDiv) && !flush) begin
                        r_state      <= START;
                        r_opIsDiv    <= w_isDiv;
                        pending_insn <= dx_insn;
                        ctrl_MULT    <= !w_isDiv;
                        ctrl_DIV     <= w_isDiv;
                        mult_ongoing <= 1'b1;
                    end
                end
                START: begin
                    r_state <= BUSY;
                    r_cnt   <= '0;
                end
                BUSY: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (data_resultRDY || r_cnt == LAST_CNT) begin
                        r_state  <= DONE;
                        wb_valid <= 1'b1;
                        // A unit exception and a timeout both report through the fixed r30 status path.
                        if (data_resultRDY && !data_exception) begin
                            wb_rd   <= pending_insn[26:22];
                            wb_data <= data_result;
                        end else begin
                            wb_rd        <= 5'd30;
                            wb_data      <= r_opIsDiv ? 32'd5 : 32'd4;
                            wb_exception <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_state      <= IDLE;
                    mult_ongoing <= 1'b0;
                    pending_insn <= 32'h0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_tracker.sv
// Self-checking bench for multdiv_tracker: directed scenarios with literal expectations
// followed by randomized traffic compared every cycle against an op-lifetime model.
module tb_multdiv_tracker;

    localparam int TIMEOUT = 40;
    localparam int CNT_W   = 6;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] dxInsn = 32'h0;
    logic        flush = 1'b0;
    logic        dataRdy = 1'b0;
    logic        dataExc = 1'b0;
    logic [31:0] dataRes = 32'h0;
    logic        ctrlMult, ctrlDiv, multOngoing, wbValid, wbExc;
    logic [31:0] pendingInsn, wbData;
    logic [4:0]  wbRd;

    int checks = 0;
    int errors = 0;

    multdiv_tracker #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .dx_insn(dxInsn), .flush(flush),
        .data_resultRDY(dataRdy), .data_exception(dataExc), .data_result(dataRes),
        .ctrl_MULT(ctrlMult), .ctrl_DIV(ctrlDiv), .mult_ongoing(multOngoing),
        .pending_insn(pendingInsn), .wb_valid(wbValid), .wb_rd(wbRd),
        .wb_data(wbData), .wb_exception(wbExc)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mdInsn(input logic [4:0] rd, input logic isDiv);
        return {5'b0, rd, 5'd1, 5'd2, 5'b0, isDiv ? 5'b00111 : 5'b00110, 2'b0};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model tracks one op by its age: age 0 is the start-pulse cycle, ages 1..TIMEOUT are busy cycles.
    bit          mBusy = 0, mWb = 0, mIsDiv = 0;
    int          mAge = 0;
    logic [31:0] mInsn = 0;
    logic        eCtrlMult = 0, eCtrlDiv = 0, eOngoing = 0, eWbValid = 0, eWbExc = 0;
    logic [31:0] ePending = 0, eWbData = 0;
    logic [4:0]  eWbRd = 0;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            mBusy = 0; mWb = 0; mAge = 0; mInsn = 0; mIsDiv = 0;
            eCtrlMult = 0; eCtrlDiv = 0; eOngoing = 0; ePending = 0;
            eWbValid = 0; eWbRd = 0; eWbData = 0; eWbExc = 0;
        end else begin
            eCtrlMult = 0; eCtrlDiv = 0; eWbValid = 0; eWbRd = 0; eWbData = 0; eWbExc = 0;
            if (mWb) begin
                mWb = 0; mBusy = 0; mInsn = 0;
            end else if (mBusy) begin
                if (mAge >= 1 && (dataRdy || mAge == TIMEOUT)) begin
                    mWb = 1; eWbValid = 1;
                    if (dataRdy && !dataExc) begin
                        eWbRd = mInsn[26:22]; eWbData = dataRes;
                    end else begin
                        eWbRd = 5'd30; eWbData = mIsDiv ? 32'd5 : 32'd4; eWbExc = 1;
                    end
                end
                mAge++;
            end else if (dxInsn[31:27] == 5'b0 && (dxInsn[6:2] == 5'd6 || dxInsn[6:2] == 5'd7) && !flush) begin
                mBusy = 1; mAge = 0; mInsn = dxInsn; mIsDiv = (dxInsn[6:2] == 5'd7);
                eCtrlMult = !mIsDiv; eCtrlDiv = mIsDiv;
            end
            eOngoing = mBusy;
            ePending = mInsn;
        end
    end

    always @(negedge clock) begin
        checkOutput("ctrl_MULT", 32'(ctrlMult), 32'(eCtrlMult));
        checkOutput("ctrl_DIV", 32'(ctrlDiv), 32'(eCtrlDiv));
        checkOutput("mult_ongoing", 32'(multOngoing), 32'(eOngoing));
        checkOutput("pending_insn", pendingInsn, ePending);
        checkOutput("wb_valid", 32'(wbValid), 32'(eWbValid));
        checkOutput("wb_rd", 32'(wbRd), 32'(eWbRd));
        checkOutput("wb_data", wbData, eWbData);
        checkOutput("wb_exception", 32'(wbExc), 32'(eWbExc));
    end

    // After this returns, the outputs visible belong to the same cycle as the inputs just driven.
    task automatic applyStimulus(input logic [31:0] insn, input logic fl, input logic rdy,
                                 input logic exc, input logic [31:0] res);
        @(negedge clock);
        dxInsn = insn; flush = fl; dataRdy = rdy; dataExc = exc; dataRes = res;
    endtask

    initial begin
        logic [31:0] mulA, mulB, divA, addA, insn;
        int          n, pulseCyc, rdyPct;
        bit          found;
        mulA = mdInsn(5'd7, 1'b0);
        mulB = mdInsn(5'd9, 1'b0);
        divA = mdInsn(5'd12, 1'b1);
        addA = {5'b0, 5'd3, 5'd1, 5'd2, 5'b0, 5'b00000, 2'b0};

        #2;
        checkOutput("reset_ongoing", 32'(multOngoing), 32'd0);
        checkOutput("reset_pending", pendingInsn, 32'h0);
        @(negedge clock); @(negedge clock);
        reset = 1'b0;
        applyStimulus(32'h0, 0, 0, 0, 0);

        // Multiply with the result arriving in cycle 5.
        applyStimulus(mulA, 0, 0, 0, 0);
        for (int c = 1; c <= 7; c++) begin
            applyStimulus(32'h0, 0, c == 5, 0, c == 5 ? 32'd42 : 32'd0);
            checkOutput("mult_ctrl_pulse", 32'(ctrlMult), 32'(c == 1));
            checkOutput("mult_ongoing_win", 32'(multOngoing), 32'(c <= 6));
            if (c == 6) begin
                checkOutput("mult_wb_valid", 32'(wbValid), 32'd1);
                checkOutput("mult_wb_rd", 32'(wbRd), 32'd7);
                checkOutput("mult_wb_data", wbData, 32'd42);
            end
            if (c == 7) checkOutput("mult_pending_clr", pendingInsn, 32'h0);
        end

        // Divide completing with a unit exception.
        applyStimulus(divA, 0, 0, 0, 0);
        applyStimulus(32'h0, 0, 0, 0, 0);
        checkOutput("div_ctrl_pulse", 32'(ctrlDiv), 32'd1);
        applyStimulus(32'h0, 0, 1, 1, 32'h1234);
        applyStimulus(32'h0, 0, 0, 0, 0);
        checkOutput("div_exc_rd", 32'(wbRd), 32'd30);
        checkOutput("div_exc_data", wbData, 32'd5);
        checkOutput("div_exc_flag", 32'(wbExc), 32'd1);
        applyStimulus(32'h0, 0, 0, 0, 0);

        // Timeout: the unit never answers.
        applyStimulus(mulA, 0, 0, 0, 0);
        found = 0; pulseCyc = -1;
        for (n = 1; n <= 60 && !found; n++) begin
            applyStimulus(32'h0, 0, 0, 0, 0);
            if (ctrlMult) pulseCyc = n;
            if (wbValid) begin
                found = 1;
                checkOutput("timeout_latency", 32'(n - pulseCyc), 32'(TIMEOUT + 1));
                checkOutput("timeout_rd", 32'(wbRd), 32'd30);
                checkOutput("timeout_data", wbData, 32'd4);
                checkOutput("timeout_exc", 32'(wbExc), 32'd1);
            end
        end
        if (!found) begin
            checks++; errors++;
            $display("[TB] FAIL timeout_wait: got no wb_valid expected one within 60 cycles");
        end
        applyStimulus(32'h0, 0, 0, 0, 0);

        // Flushed mult and a plain add must not issue.
        applyStimulus(mulA, 1, 0, 0, 0);
        applyStimulus(addA, 0, 0, 0, 0);
        checkOutput("flush_no_pulse", 32'(ctrlMult), 32'd0);
        applyStimulus(32'h0, 0, 0, 0, 0);
        checkOutput("add_no_issue", 32'(multOngoing), 32'd0);

        // Back-to-back: second mult waits in D/X and issues once the first is written back.
        applyStimulus(mulA, 0, 0, 0, 0);
        for (int c = 1; c <= 10; c++) begin
            applyStimulus(c <= 6 ? mulB : 32'h0, 0, c == 4 || c == 9, 0, 32'(c));
            if (c >= 2 && c <= 6) checkOutput("b2b_no_pulse", 32'(ctrlMult), 32'd0);
            if (c == 5) checkOutput("b2b_first_wb", 32'(wbRd), 32'd7);
            if (c == 7) begin
                checkOutput("b2b_reissue", 32'(ctrlMult), 32'd1);
                checkOutput("b2b_pending", pendingInsn, mulB);
            end
            if (c == 10) checkOutput("b2b_second_wb", 32'(wbRd), 32'd9);
        end
        applyStimulus(32'h0, 0, 0, 0, 0);

        // Reset asserted between edges while busy.
        applyStimulus(mulA, 0, 0, 0, 0);
        applyStimulus(32'h0, 0, 0, 0, 0);
        applyStimulus(32'h0, 0, 0, 0, 0);
        #2 reset = 1'b1;
        #1;
        checkOutput("rst_ongoing", 32'(multOngoing), 32'd0);
        checkOutput("rst_pending", pendingInsn, 32'h0);
        @(negedge clock);
        reset = 1'b0; dataRdy = 1'b1; dataRes = 32'd99;
        for (int c = 0; c < 4; c++) begin
            applyStimulus(32'h0, 0, 0, 0, 0);
            checkOutput("rst_no_wb", 32'(wbValid), 32'd0);
        end

        // Randomized traffic; the response rate varies per block so timeouts also occur.
        rdyPct = 10;
        for (int i = 0; i < 4000; i++) begin
            if (i % 128 == 0) rdyPct = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(5, 40);
            case ($urandom_range(0, 3))
                0: insn = mdInsn(5'($urandom), 1'b0);
                1: insn = mdInsn(5'($urandom), 1'b1);
                2: insn = {5'b0, 5'($urandom), 15'($urandom), 5'b00000, 2'b0};
                default: insn = $urandom;
            endcase
            applyStimulus(insn, $urandom_range(0, 3) == 0, $urandom_range(0, 99) < rdyPct,
                          $urandom_range(0, 3) == 0, $urandom);
        end
        applyStimulus(32'h0, 0, 0, 0, 0);
        @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
